// File: rtl/ret_stack_ctrl.sv
// Return-address stack for CALL/RET sequencing: circular buffer with depth tracking,
// sticky overflow/underflow flags and a fault FSM that freezes the stack until err_clr.
module ret_stack_ctrl #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] ret_pc,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              fault
);

  localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PtrTwo   = PTR_W'(2);
  localparam logic [PTR_W:0]   CountMax = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CountOne = (PTR_W+1)'(1);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    sp_q, sp_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [ADDR_W-1:0]   top_q, top_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [ADDR_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [PTR_W-1:0]    mem_waddr;
  logic [PTR_W-1:0]    pop_idx;
  logic                is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CountMax);
  // Entry that becomes top-of-stack after a pop (two below the write slot).
  assign pop_idx  = sp_q - PtrTwo;

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    count_d   = count_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = sp_q;

    if (en) begin
      if (err_clr) begin
        state_d = StRun;
        sp_d    = '0;
        count_d = '0;
        top_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end else if (state_q == StRun) begin
        case ({call, ret})
          2'b10: begin
            // A push while full still lands, overwriting the oldest entry via wrap.
            mem_we    = 1'b1;
            mem_waddr = sp_q;
            sp_d      = sp_q + PtrOne;
            top_d     = ret_pc;
            if (is_full) begin
              ovf_d   = 1'b1;
              state_d = StFault;
            end else begin
              count_d = count_q + CountOne;
            end
          end
          2'b01: begin
            if (is_empty) begin
              unf_d   = 1'b1;
              state_d = StFault;
            end else begin
              sp_d    = sp_q - PtrOne;
              count_d = count_q - CountOne;
              top_d   = (count_q == CountOne) ? '0 : mem[pop_idx];
            end
          end
          2'b11: begin
            // Tail-call: replace the current top in place.
            if (is_empty) begin
              unf_d   = 1'b1;
              state_d = StFault;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = sp_q - PtrOne;
              top_d     = ret_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      sp_q    <= '0;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= ret_pc;
    end
  end

  assign top_addr      = top_q;
  assign count         = count_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign fault         = (state_q == StFault);

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Directed bench for ret_stack_ctrl: push/pop, overflow wrap, underflow, tail-call,
// stall and asynchronous reset, each with hand-computed expectations.
module tb_ret_stack_ctrl;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] ret_pc;
  logic              err_clr;
  logic [ADDR_W-1:0] top_addr;
  logic              empty;
  logic              full;
  logic [4:0]        count;
  logic              overflow_err;
  logic              underflow_err;
  logic              fault;

  int n_checks;
  int n_fail;

  ret_stack_ctrl #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .call         (call),
    .ret          (ret),
    .ret_pc       (ret_pc),
    .err_clr      (err_clr),
    .top_addr     (top_addr),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic tick(input logic e, input logic c, input logic r, input logic [ADDR_W-1:0] pc,
                      input logic clr);
    en      = e;
    call    = c;
    ret     = r;
    ret_pc  = pc;
    err_clr = clr;
    @(posedge clk);
    #1;
    en      = 1'b1;
    call    = 1'b0;
    ret     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (count !== 5'd0 || top_addr !== 19'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data got count=%0d top=%h empty=%b full=%b want 0 0 1 0",
               count, top_addr, empty, full);
    end
    n_checks++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got ovf=%b unf=%b fault=%b want 0 0 0",
               overflow_err, underflow_err, fault);
    end
  endtask

  task automatic test_push_pop();
    logic [ADDR_W-1:0] exp_top [3];
    exp_top[0] = 19'h00020;
    exp_top[1] = 19'h00010;
    exp_top[2] = 19'h00000;
    tick(1, 1, 0, 19'h00010, 0);
    tick(1, 1, 0, 19'h00020, 0);
    tick(1, 1, 0, 19'h00030, 0);
    n_checks++;
    if (count !== 5'd3 || top_addr !== 19'h00030) begin
      n_fail++;
      $display("FAIL push3 got count=%0d top=%h want 3 00030", count, top_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1, 19'h0, 0);
      n_checks++;
      if (top_addr !== exp_top[i] || count !== 5'(2 - i)) begin
        n_fail++;
        $display("FAIL pop%0d got top=%h count=%0d want %h %0d",
                 i, top_addr, count, exp_top[i], 2 - i);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || overflow_err !== 1'b0 || underflow_err !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_end got empty=%b ovf=%b unf=%b fault=%b want 1 0 0 0",
               empty, overflow_err, underflow_err, fault);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) begin
      tick(1, 1, 0, 19'(i), 0);
      if (i <= 16) begin
        n_checks++;
        if (count !== 5'(i) || top_addr !== 19'(i) || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL fill%0d got count=%0d top=%h fault=%b want %0d %h 0",
                   i, count, top_addr, fault, i, i);
        end
      end
    end
    n_checks++;
    if (count !== 5'd16 || full !== 1'b1 || overflow_err !== 1'b1 || fault !== 1'b1 ||
        top_addr !== 19'd17) begin
      n_fail++;
      $display("FAIL ovf got count=%0d full=%b ovf=%b fault=%b top=%h want 16 1 1 1 11",
               count, full, overflow_err, fault, top_addr);
    end
    tick(1, 0, 1, 19'h0, 0);
    n_checks++;
    if (count !== 5'd16 || top_addr !== 19'd17 || underflow_err !== 1'b0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_ret_ignored got count=%0d top=%h unf=%b fault=%b want 16 11 0 1",
               count, top_addr, underflow_err, fault);
    end
    tick(1, 0, 0, 19'h0, 1);
    n_checks++;
    if (count !== 5'd0 || fault !== 1'b0 || overflow_err !== 1'b0 || top_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL ovf_clr got count=%0d fault=%b ovf=%b top=%h want 0 0 0 0",
               count, fault, overflow_err, top_addr);
    end
  endtask

  task automatic test_underflow_clr();
    tick(1, 0, 1, 19'h0, 0);
    n_checks++;
    if (underflow_err !== 1'b1 || fault !== 1'b1 || count !== 5'd0 || top_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL unf got unf=%b fault=%b count=%0d top=%h want 1 1 0 0",
               underflow_err, fault, count, top_addr);
    end
    tick(1, 1, 0, 19'h00055, 0);
    n_checks++;
    if (count !== 5'd0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_call_ignored got count=%0d fault=%b want 0 1", count, fault);
    end
    tick(1, 0, 0, 19'h0, 1);
    n_checks++;
    if (fault !== 1'b0 || underflow_err !== 1'b0 || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_clr got fault=%b unf=%b ovf=%b want 0 0 0",
               fault, underflow_err, overflow_err);
    end
    tick(1, 1, 0, 19'h00100, 0);
    n_checks++;
    if (count !== 5'd1 || top_addr !== 19'h00100) begin
      n_fail++;
      $display("FAIL unf_recover got count=%0d top=%h want 1 00100", count, top_addr);
    end
    tick(1, 0, 0, 19'h0, 1);
  endtask

  task automatic test_tail_call();
    tick(1, 1, 0, 19'h5, 0);
    tick(1, 1, 0, 19'h6, 0);
    tick(1, 1, 1, 19'h7, 0);
    n_checks++;
    if (count !== 5'd2 || top_addr !== 19'h7 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL tail got count=%0d top=%h fault=%b want 2 7 0", count, top_addr, fault);
    end
    tick(1, 0, 1, 19'h0, 0);
    n_checks++;
    if (count !== 5'd1 || top_addr !== 19'h5) begin
      n_fail++;
      $display("FAIL tail_pop got count=%0d top=%h want 1 5", count, top_addr);
    end
    tick(1, 0, 0, 19'h0, 1);
    tick(1, 1, 1, 19'h8, 0);
    n_checks++;
    if (underflow_err !== 1'b1 || fault !== 1'b1 || count !== 5'd0 || top_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL tail_empty got unf=%b fault=%b count=%0d top=%h want 1 1 0 0",
               underflow_err, fault, count, top_addr);
    end
    tick(1, 0, 0, 19'h0, 1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 19'h9, 0);
      n_checks++;
      if (count !== 5'd0 || top_addr !== 19'd0) begin
        n_fail++;
        $display("FAIL stall%0d got count=%0d top=%h want 0 0", i, count, top_addr);
      end
    end
    tick(0, 0, 0, 19'h0, 1);
    tick(1, 1, 0, 19'h9, 0);
    n_checks++;
    if (count !== 5'd1 || top_addr !== 19'h9) begin
      n_fail++;
      $display("FAIL stall_release got count=%0d top=%h want 1 9", count, top_addr);
    end
    tick(1, 0, 0, 19'h0, 0);
    n_checks++;
    if (count !== 5'd1 || top_addr !== 19'h9) begin
      n_fail++;
      $display("FAIL stall_once got count=%0d top=%h want 1 9", count, top_addr);
    end
    tick(1, 0, 0, 19'h0, 1);
  endtask

  task automatic test_async_reset();
    tick(1, 1, 0, 19'h11, 0);
    tick(1, 1, 0, 19'h22, 0);
    tick(1, 0, 1, 19'h0, 0);
    tick(1, 0, 1, 19'h0, 0);
    tick(1, 0, 1, 19'h0, 0);
    n_checks++;
    if (fault !== 1'b1 || underflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst got fault=%b unf=%b want 1 1", fault, underflow_err);
    end
    tick(1, 0, 0, 19'h0, 1);
    tick(1, 1, 0, 19'h11, 0);
    tick(1, 1, 0, 19'h22, 0);
    n_checks++;
    if (count !== 5'd2 || top_addr !== 19'h22) begin
      n_fail++;
      $display("FAIL pre_rst_push got count=%0d top=%h want 2 22", count, top_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 5'd0 || top_addr !== 19'd0 || fault !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst got count=%0d top=%h fault=%b empty=%b want 0 0 0 1",
               count, top_addr, fault, empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 1, 0, 19'h33, 0);
    n_checks++;
    if (count !== 5'd1 || top_addr !== 19'h33 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst got count=%0d top=%h fault=%b want 1 33 0",
               count, top_addr, fault);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    call     = 1'b0;
    ret      = 1'b0;
    ret_pc   = '0;
    err_clr  = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_push_pop();
    test_overflow();
    test_underflow_clr();
    test_tail_call();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ret_stack_ctrl.md
Name: ret_stack_ctrl

Overview:
- Hardware return-address stack controller that sequences CALL/RET control flow for the 19-bit CPU.
- Pushes the return PC on CALL, and on RET pops it and presents it to the PC-select mux.
- Tracks depth and detects overflow/underflow; a fault FSM freezes the stack and signals the hazard unit until software clears it.
- Sits between the main decoder's Call/Ret strobes and the fetch-stage PC mux.

Parameters:
- ADDR_W, 19, width of instruction addresses pushed/popped.
- DEPTH, 16, number of stack entries; power of two, >= 2. Local PTR_W = clog2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  pipeline advance; 0 = stall, no call/ret/err_clr sampled.
- call  input  1  CALL decoded this cycle (push request).
- ret  input  1  RET decoded this cycle (pop request).
- ret_pc  input  ADDR_W  return address to push (PC+1 from datapath).
- err_clr  input  1  clear fault and flush stack.
- top_addr  output  ADDR_W  current top-of-stack; 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- overflow_err  output  1  sticky, push occurred while full.
- underflow_err  output  1  sticky, pop attempted while empty.
- fault  output  1  FSM in S_FAULT; hazard unit stalls fetch.

Behaviour:
- Reset (rst_n=0, async): sp=0, count=0, top_addr=0, empty=1, full=0, both error flags=0, fault=0, state=S_RUN. Storage array need not be reset.
- All state updates occur on the rising clk edge, and only when en=1. With en=0 every register holds.
- Outputs are registered. An op sampled at edge N is reflected on top_addr/count/flags after edge N (1-cycle latency). top_addr always equals the last pushed and not yet popped entry.
- Priority: rst_n > err_clr > call/ret.
- FSM states: S_RUN, S_FAULT.
  - S_RUN -> S_FAULT on overflow or underflow event.
  - S_FAULT -> S_RUN only on en & err_clr.
  - In S_FAULT, call/ret are ignored: no push, no pop, no flag change.
- Storage is a circular buffer. sp is the next write slot, PTR_W bits, and wraps modulo DEPTH.
- Push (S_RUN, call=1, ret=0):
  - mem[sp]<=ret_pc, sp<=sp+1, top_addr<=ret_pc.
  - count<=count+1, saturating at DEPTH.
- Push when full:
  - The push still occurs and overwrites the oldest entry via wrap; count stays DEPTH.
  - overflow_err<=1; state -> S_FAULT.
- Pop (S_RUN, ret=1, call=0, count>0):
  - sp<=sp-1, count<=count-1.
  - top_addr<=mem[sp-2], or 0 if the new count is 0.
- Pop when empty: sp/count/top unchanged; underflow_err<=1; state -> S_FAULT.
- call & ret in the same cycle (tail-call replacement; the decoder never issues this, but it is defined):
  - If count>0: the top entry is replaced: mem[sp-1]<=ret_pc, top_addr<=ret_pc, sp/count unchanged, no error.
  - If empty: underflow_err<=1, S_FAULT, no push.
- err_clr (en=1, any state): sp=0, count=0, top_addr=0, both flags cleared, state=S_RUN. call/ret in the same cycle are ignored.
- After DEPTH pops following a wrap-overflow, the stack is empty. Entries lost to overwrite are not recovered.
- Reset asserted mid-sequence clears everything immediately (async); the first edge after deassertion behaves as from a clean reset.
- Widths: count is PTR_W+1 bits so DEPTH is representable. sp arithmetic is modulo 2^PTR_W. ret_pc is stored unmodified.

Test Plan:
- Reset, then en=1, call with ret_pc=0x00010, 0x00020, 0x00030 -> count=3, top_addr=0x00030; then ret x3 -> top_addr 0x00020, 0x00010, 0, empty=1, no errors.
- 17 consecutive calls (DEPTH=16) with ret_pc=1..17 -> count saturates at 16, full=1. 17th push sets overflow_err=1, fault=1, top_addr=17. A following ret is ignored (count stays 16).
- ret while empty -> underflow_err=1, fault=1, count=0, top_addr=0. Then err_clr -> fault=0, flags=0, next call 0x00100 gives count=1, top_addr=0x00100.
- count=2 (tops 0x5, 0x6); call+ret same cycle with ret_pc=0x7 -> count=2, top_addr=0x7. A following ret gives top_addr=0x5.
- en=0 held for 3 cycles with call=1, ret_pc=0x9 -> no state change. The en=1 edge then pushes exactly once.
- Push 0x11, 0x22, then assert rst_n=0 between edges -> outputs return to reset values immediately (count=0, top_addr=0, fault=0) without a clock edge.
